frame_writer: RTL and testbench
===============================

FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 Parameter WIDTH, default 4, bits per pixel written to the framebuffer.
REQ-002 Parameter DEPTH, default `DISPLAY_WIDTH*`DISPLAY_HEIGHT, pixels per frame.
REQ-003 Parameter ADDR_LEN, default `ADDR_BITS, framebuffer address width.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pixel_valid_in  input  1  producer has a pixel on pixel_data_in.
REQ-007 pixel_data_in  input  WIDTH  pixel value, raster order.
REQ-008 pixel_ready_out  output  1  writer accepts a pixel this cycle.
REQ-009 vblank_in  input  1  display in vertical blanking (level).
REQ-010 write_enable  output  1  write strobe to bram_manager back buffer.
REQ-011 write_addr  output  ADDR_LEN  back-buffer write address.
REQ-012 write_data  output  WIDTH  back-buffer write data.
REQ-013 swap_buffers  output  1  one-cycle swap request to bram_manager.
REQ-014 frame_count  output  16  completed (swapped) frames, wraps.
REQ-015 busy_out  output  1  high whenever state is not FILL.

Function
REQ-016 States SHALL be FILL, WAIT_VBLANK, SWAP, SETTLE.
REQ-017 pixel_ready_out SHALL be 1 only in FILL (registered state decode, not dependent on pixel_valid_in).
REQ-018 Handshake occurs when pixel_valid_in && pixel_ready_out; no other cycle SHALL write or advance the counter.
REQ-019 On handshake, the next cycle SHALL present write_enable=1, write_addr=pixel index (0..DEPTH-1), write_data=accepted pixel; otherwise write_enable=0 (write latency 1 cycle).
REQ-020 Pixel index SHALL increment by 1 per handshake, starting at 0 each frame.
REQ-021 Handshake at index DEPTH-1 SHALL move FILL->WAIT_VBLANK and reset index to 0; pixel_ready_out SHALL be 0 from the next cycle.
REQ-022 WAIT_VBLANK->SWAP when vblank_in=1; vblank_in while in FILL SHALL have no effect.
REQ-023 In SWAP, swap_buffers SHALL be 1 for exactly one cycle; state then SETTLE.
REQ-024 SETTLE SHALL last exactly one cycle, then FILL.
REQ-025 frame_count SHALL increment (mod 2^16) in the cycle swap_buffers is 1.
REQ-026 Pixel offered while not ready SHALL be neither written nor counted; producer holds it.
REQ-027 Minimum frame-to-frame gap: last-pixel handshake to next-frame first ready = 3 cycles when vblank_in already high.
REQ-028 write_enable and swap_buffers SHALL never be 1 in the same cycle.

Reset
REQ-029 On rst=1: state FILL, index 0, write_enable 0, write_addr 0, write_data 0, swap_buffers 0, frame_count 0, busy_out 0.
REQ-030 Reset mid-frame or mid-WAIT_VBLANK SHALL discard the partial frame with no swap issued; a pending write in the reset cycle SHALL be suppressed.

Structure
REQ-031 DISPLAY_WIDTH, DISPLAY_HEIGHT, ADDR_BITS SHALL come from the shared types.sv header; no local redefinition.
REQ-032 State encoding SHALL be a typedef enum local to the module.
REQ-033 Pixel index SHALL be one sub-module, pixel_addr_counter (clear, enable, terminal-count flag at DEPTH-1).

Verification (bench DEPTH=16, WIDTH=4)
REQ-034 16 back-to-back valid pixels 0x0..0xF, vblank_in=1 -> writes addr 0..15 data 0..F on consecutive cycles, swap pulse 2 cycles after last write, frame_count=1.
REQ-035 Full frame with vblank_in=0 for 20 cycles then 1 -> swap_buffers stays 0, busy_out=1, pixel_ready_out=0 throughout; single swap after vblank rises.
REQ-036 pixel_valid_in toggling 1,0,1,0 -> 8 writes in 16 cycles, addresses 0..7 contiguous, no gaps in index.
REQ-037 rst asserted after 7 pixels -> all outputs zero next cycle, no swap; next frame writes start at addr 0.
REQ-038 vblank_in=1 during FILL at pixel 5 -> no swap until pixel 15 accepted.
REQ-039 65536 frames -> frame_count wraps to 0.

Source files
------------

// File: rtl/frame_writer_pkg.sv
// /*------------------------------------------------------------------*/
// /* frame_writer_pkg : shared types for the frame writer             */
// /* Rev 1.0                                                          */
// /*------------------------------------------------------------------*/
`include "types.sv"
`default_nettype none

package frame_writer_pkg;

  localparam int FRAME_COUNT_WIDTH = 16;

  typedef logic [FRAME_COUNT_WIDTH-1:0] frame_count_t;

  function automatic frame_count_t next_frame_count(input frame_count_t cur);
    return cur + frame_count_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_addr_counter.sv
// /*------------------------------------------------------------------*/
// /* pixel_addr_counter : raster pixel index with terminal flag       */
// /* Rev 1.0                                                          */
// /*------------------------------------------------------------------*/
`default_nettype none

module pixel_addr_counter #(
  parameter int DEPTH    = 16,
  parameter int ADDR_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  output logic [ADDR_LEN-1:0] count,
  output logic                terminal
);

  logic [ADDR_LEN-1:0] r_count;

  // Clear wins over enable so the final pixel of a frame rolls straight to 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + ADDR_LEN'(1);
    end
  end

  assign count    = r_count;
  assign terminal = (r_count == ADDR_LEN'(DEPTH - 1));

endmodule

`default_nettype wire

// File: rtl/types.sv
// Shared display geometry macros for the framebuffer path.
`ifndef TYPES_SV
`define TYPES_SV
`default_nettype none
`define DISPLAY_WIDTH  160
`define DISPLAY_HEIGHT 120
`define ADDR_BITS      15
`default_nettype wire
`endif

// File: rtl/frame_writer.sv
// /*------------------------------------------------------------------*/
// /* frame_writer : streams pixels into the back buffer, swaps on vbl */
// /* Rev 1.0                                                          */
// /*------------------------------------------------------------------*/
`include "types.sv"
`default_nettype none

module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = `DISPLAY_WIDTH * `DISPLAY_HEIGHT,
  parameter int ADDR_LEN = `ADDR_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pixel_valid_in,
  input  logic [WIDTH-1:0]    pixel_data_in,
  output logic                pixel_ready_out,
  input  logic                vblank_in,
  output logic                write_enable,
  output logic [ADDR_LEN-1:0] write_addr,
  output logic [WIDTH-1:0]    write_data,
  output logic                swap_buffers,
  output logic [15:0]         frame_count,
  output logic                busy_out
);

  typedef enum logic [1:0] {
    FILL        = 2'd0,
    WAIT_VBLANK = 2'd1,
    SWAP        = 2'd2,
    SETTLE      = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_write_enable;
  logic [ADDR_LEN-1:0] r_write_addr;
  logic [WIDTH-1:0]    r_write_data;
  logic                r_swap_buffers;
  frame_count_t        r_frame_count;

  logic                w_handshake;
  logic                w_last_pixel;
  logic [ADDR_LEN-1:0] w_pixel_idx;

  assign pixel_ready_out = (r_state == FILL);
  assign busy_out        = (r_state != FILL);
  assign w_handshake     = pixel_valid_in && pixel_ready_out;

  pixel_addr_counter #(
    .DEPTH    (DEPTH),
    .ADDR_LEN (ADDR_LEN)
  ) u_pixel_addr_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_handshake && w_last_pixel),
    .enable   (w_handshake),
    .count    (w_pixel_idx),
    .terminal (w_last_pixel)
  );

  // The swap strobe and frame count are registered off the SWAP state, so
  // they appear together one cycle later while the FSM sits in SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FILL;
      r_write_enable <= 1'b0;
      r_write_addr   <= '0;
      r_write_data   <= '0;
      r_swap_buffers <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      r_write_enable <= w_handshake;
      r_swap_buffers <= 1'b0;
      if (w_handshake) begin
        r_write_addr <= w_pixel_idx;
        r_write_data <= pixel_data_in;
      end
      case (r_state)
        FILL: begin
          if (w_handshake && w_last_pixel) begin
            r_state <= WAIT_VBLANK;
          end
        end
        WAIT_VBLANK: begin
          if (vblank_in) begin
            r_state <= SWAP;
          end
        end
        SWAP: begin
          r_swap_buffers <= 1'b1;
          r_frame_count  <= next_frame_count(r_frame_count);
          r_state        <= SETTLE;
        end
        SETTLE: begin
          r_state <= FILL;
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign write_enable = r_write_enable;
  assign write_addr   = r_write_addr;
  assign write_data   = r_write_data;
  assign swap_buffers = r_swap_buffers;
  assign frame_count  = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: directed table, corner sequences,
// and randomized traffic against a timestamp-based reference model.
`default_nettype none

module tb_frame_writer;

  localparam int W     = 4;
  localparam int D     = 16;
  localparam int AL    = 4;

  logic          clk;
  logic          rst;
  logic          pixel_valid_in;
  logic [W-1:0]  pixel_data_in;
  logic          pixel_ready_out;
  logic          vblank_in;
  logic          write_enable;
  logic [AL-1:0] write_addr;
  logic [W-1:0]  write_data;
  logic          swap_buffers;
  logic [15:0]   frame_count;
  logic          busy_out;

  frame_writer #(
    .WIDTH    (W),
    .DEPTH    (D),
    .ADDR_LEN (AL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pixel_valid_in  (pixel_valid_in),
    .pixel_data_in   (pixel_data_in),
    .pixel_ready_out (pixel_ready_out),
    .vblank_in       (vblank_in),
    .write_enable    (write_enable),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .swap_buffers    (swap_buffers),
    .frame_count     (frame_count),
    .busy_out        (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is DEPTH accepted pixels; once complete, the
  // first vblank seen schedules the swap two cycles out and resumption three.
  int          m_cyc;
  int          m_idx;
  bit          m_waiting;
  int          m_swap_cyc;
  int          m_resume_cyc;
  logic [15:0] m_frames;
  bit          e_we;
  logic [3:0]  e_addr;
  logic [3:0]  e_data;
  bit          e_swap;
  int          swaps_seen;

  function automatic bit m_ready();
    return !m_waiting && (m_cyc >= m_resume_cyc);
  endfunction

  task automatic model_reset();
    m_cyc++;
    m_idx = 0; m_waiting = 0; m_swap_cyc = -1; m_resume_cyc = 0;
    m_frames = '0; e_we = 0; e_addr = '0; e_data = '0; e_swap = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] d, input bit vb, input bit r);
    bit hs;
    bit was_waiting;
    if (r) begin
      model_reset();
      return;
    end
    hs = v && m_ready();
    was_waiting = m_waiting;
    e_we = hs;
    if (was_waiting && vb) begin
      m_swap_cyc = m_cyc + 2;
      m_resume_cyc = m_cyc + 3;
      m_waiting = 0;
    end
    if (hs) begin
      e_addr = 4'(m_idx);
      e_data = d;
      m_idx++;
      if (m_idx == D) begin
        m_idx = 0;
        m_waiting = 1;
      end
    end
    m_cyc++;
    e_swap = (m_cyc == m_swap_cyc);
    if (e_swap) m_frames = m_frames + 16'd1;
  endtask

  task automatic apply(input bit v, input logic [3:0] d, input bit vb, input bit r);
    @(negedge clk);
    pixel_valid_in = v;
    pixel_data_in = d;
    vblank_in = vb;
    rst = r;
    #1;
  endtask

  task automatic check_model();
    chk("ready", pixel_ready_out, m_ready());
    chk("busy", busy_out, !m_ready());
    chk("write_enable", write_enable, e_we);
    chk("swap_buffers", swap_buffers, e_swap);
    chk("frame_count", frame_count, m_frames);
    chk("we_and_swap", write_enable && swap_buffers, 0);
    if (e_we) begin
      chk("write_addr", write_addr, e_addr);
      chk("write_data", write_data, e_data);
    end
  endtask

  task automatic cycle(input bit v, input logic [3:0] d, input bit vb, input bit r);
    apply(v, d, vb, r);
    check_model();
    if (swap_buffers) swaps_seen++;
    model_step(v, d, vb, r);
  endtask

  typedef struct {
    bit         valid;
    logic [3:0] data;
    bit         vblank;
    bit         x_ready;
    bit         x_we;
    logic [3:0] x_addr;
    logic [3:0] x_data;
    bit         x_swap;
    logic [15:0] x_fc;
  } vec_t;

  vec_t tbl [20];

  initial begin
    m_cyc = 0;
    swaps_seen = 0;
    model_reset();
    pixel_valid_in = 0; pixel_data_in = '0; vblank_in = 0; rst = 1;

    // Back-to-back frame with vblank already high; row k is cycle k after reset.
    for (int k = 0; k < 20; k++) begin
      tbl[k].valid   = (k < 16);
      tbl[k].data    = 4'(k);
      tbl[k].vblank  = 1'b1;
      tbl[k].x_ready = (k <= 15) || (k == 19);
      tbl[k].x_we    = (k >= 1) && (k <= 16);
      tbl[k].x_addr  = 4'(k - 1);
      tbl[k].x_data  = 4'(k - 1);
      tbl[k].x_swap  = (k == 18);
      tbl[k].x_fc    = (k >= 18) ? 16'd1 : 16'd0;
    end

    apply(0, 4'h0, 0, 1);
    model_step(0, 4'h0, 0, 1);
    cycle(0, 4'h0, 0, 1);
    // Reset-state check
    apply(0, 4'h0, 0, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_addr", write_addr, 0);
    chk("rst_data", write_data, 0);
    chk("rst_swap", swap_buffers, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_ready", pixel_ready_out, 1);
    model_step(0, 4'h0, 0, 0);

    for (int k = 0; k < 20; k++) begin
      apply(tbl[k].valid, tbl[k].data, tbl[k].vblank, 0);
      chk($sformatf("tbl%0d_ready", k), pixel_ready_out, tbl[k].x_ready);
      chk($sformatf("tbl%0d_we", k), write_enable, tbl[k].x_we);
      chk($sformatf("tbl%0d_swap", k), swap_buffers, tbl[k].x_swap);
      chk($sformatf("tbl%0d_fc", k), frame_count, tbl[k].x_fc);
      if (tbl[k].x_we) begin
        chk($sformatf("tbl%0d_addr", k), write_addr, tbl[k].x_addr);
        chk($sformatf("tbl%0d_data", k), write_data, tbl[k].x_data);
      end
      model_step(tbl[k].valid, tbl[k].data, tbl[k].vblank, 0);
    end

    // Frame completes with vblank low for 20 cycles, then vblank rises.
    swaps_seen = 0;
    for (int k = 0; k < 16; k++) cycle(1, 4'(k ^ 5), 0, 0);
    for (int k = 0; k < 20; k++) cycle(1, 4'h3, 0, 0);
    chk("no_swap_before_vblank", swaps_seen, 0);
    for (int k = 0; k < 4; k++) cycle(0, 4'h0, 1, 0);
    chk("single_swap_after_vblank", swaps_seen, 1);

    // Alternating valid: 8 writes over 16 cycles.
    for (int k = 0; k < 16; k++) cycle(k[0] == 1'b0, 4'(k), 0, 0);
    // Reset mid-frame after 7 more pixels, then a fresh frame from addr 0.
    for (int k = 0; k < 7; k++) cycle(1, 4'(k), 0, 0);
    cycle(1, 4'hA, 0, 1);
    cycle(0, 4'h0, 0, 0);
    chk("post_rst_fc", frame_count, 0);
    chk("post_rst_we", write_enable, 0);

    // vblank high from pixel 5 onward must not swap before the frame ends.
    swaps_seen = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(1, 4'(15 - k), (k >= 5), 0);
      if (k < 15) chk("early_vblank_no_swap", swaps_seen, 0);
    end
    for (int k = 0; k < 4; k++) cycle(0, 4'h0, 1, 0);
    chk("early_vblank_one_swap", swaps_seen, 1);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 9) < 3,
            $urandom_range(0, 199) == 0);
    end

    // Frame counter wrap: preload to 0xFFFF then complete one frame.
    cycle(0, 4'h0, 0, 1);
    cycle(0, 4'h0, 0, 0);
    force dut.r_frame_count = 16'hFFFF;
    #1;
    release dut.r_frame_count;
    m_frames = 16'hFFFF;
    for (int k = 0; k < 16; k++) cycle(1, 4'(k), 1, 0);
    for (int k = 0; k < 4; k++) cycle(0, 4'h0, 1, 0);
    chk("fc_wrap", frame_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
